// File: rtl/testout_chk.sv
// rtl/testout_chk.sv - router test-output checker: route/sequence checks, LFSR backpressure, pass/fail FSM
module testout_chk #(
    parameter int          NFLITS    = 64,
    parameter int          TIMEOUT   = 1024,
    parameter int          BP_MODE   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0][63:0] D,
    input  logic [3:0]       D_VALID,
    output logic [3:0]       D_BP,
    output logic [3:0][15:0] FLIT_CNT,
    output logic [3:0]       ROUTE_ERR,
    output logic [3:0]       SEQ_ERR,
    output logic             DONE,
    output logic             PASS
);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [31:0] exp_tbl [4][4];
    logic [19:0] total;
    logic [15:0] idle_cnt;

    logic [3:0]  acc;
    logic [3:0]  route_bad;
    logic [3:0]  seq_bad;
    logic [2:0]  acc_num;
    logic [20:0] total_sum;
    logic        end_hit;
    logic        timeout_hit;
    logic        err_any;
    logic [3:0]  bp_nxt;

    logic unused_hi;
    assign unused_hi = ^{D[0][63:36], D[1][63:36], D[2][63:36], D[3][63:36]};

    always_comb begin
        acc       = '0;
        route_bad = '0;
        seq_bad   = '0;
        acc_num   = '0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = D_VALID[i] && !D_BP[i] && (state == S_RUN);
            if (acc[i]) begin
                if (D[i][33:32] != 2'(i))
                    route_bad[i] = 1'b1;
                else if (D[i][31:0] != exp_tbl[i][D[i][35:34]])
                    seq_bad[i] = 1'b1;
            end
            acc_num = acc_num + {2'b00, acc[i]};
        end
        total_sum   = {1'b0, total} + 21'(acc_num);
        end_hit     = total_sum >= 21'(NFLITS);
        timeout_hit = (idle_cnt == 16'(TIMEOUT - 1)) && (acc == 4'h0);
        err_any     = |{ROUTE_ERR, SEQ_ERR, route_bad, seq_bad};

        state_nxt = state;
        if (state == S_RUN) begin
            if (end_hit)
                state_nxt = err_any ? S_FAIL : S_PASS;
            else if (timeout_hit)
                state_nxt = S_FAIL;
        end

        for (int i = 0; i < 4; i++)
            bp_nxt[i] = (BP_MODE != 0) && (lfsr[4*i +: 2] == 2'b00);
        if (state_nxt != S_RUN)
            bp_nxt = 4'hF;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_RUN;
            lfsr      <= LFSR_SEED;
            D_BP      <= '0;
            FLIT_CNT  <= '0;
            ROUTE_ERR <= '0;
            SEQ_ERR   <= '0;
            total     <= '0;
            idle_cnt  <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            for (int d = 0; d < 4; d++)
                for (int s = 0; s < 4; s++)
                    exp_tbl[d][s] <= '0;
        end else begin
            state <= state_nxt;
            DONE  <= (state_nxt != S_RUN);
            PASS  <= (state_nxt == S_PASS);
            D_BP  <= bp_nxt;
            if (state == S_RUN)
                lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            ROUTE_ERR <= ROUTE_ERR | route_bad;
            SEQ_ERR   <= SEQ_ERR | seq_bad;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    if (FLIT_CNT[i] != 16'hFFFF)
                        FLIT_CNT[i] <= FLIT_CNT[i] + 16'd1;
                    // match or resync both leave the entry at received seq + 1
                    if (!route_bad[i])
                        exp_tbl[i][D[i][35:34]] <= D[i][31:0] + 32'd1;
                end
            end
            total    <= (total_sum > 21'hFFFFF) ? 20'hFFFFF : total_sum[19:0];
            idle_cnt <= ((state != S_RUN) || (acc != 4'h0)) ? 16'h0 : idle_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_testout_chk.sv
// tb/tb_testout_chk.sv - randomized and directed checks of testout_chk against a behavioural model
module tb_testout_chk;

    localparam int P_NF [2] = '{8, 300};
    localparam int P_TO [2] = '{16, 64};
    localparam int P_BP [2] = '{0, 1};

    logic             CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             rst  [2];
    logic [3:0][63:0] d    [2];
    logic [3:0]       dv   [2];
    logic [3:0]       bp   [2];
    logic [3:0][15:0] cnt  [2];
    logic [3:0]       rerr [2];
    logic [3:0]       serr [2];
    logic             done [2];
    logic             pass [2];

    testout_chk #(.NFLITS(8), .TIMEOUT(16), .BP_MODE(0), .LFSR_SEED(16'hACE1)) dut0 (
        .CLK(CLK), .RST(rst[0]), .D(d[0]), .D_VALID(dv[0]), .D_BP(bp[0]),
        .FLIT_CNT(cnt[0]), .ROUTE_ERR(rerr[0]), .SEQ_ERR(serr[0]), .DONE(done[0]), .PASS(pass[0]));

    testout_chk #(.NFLITS(300), .TIMEOUT(64), .BP_MODE(1), .LFSR_SEED(16'hACE1)) dut1 (
        .CLK(CLK), .RST(rst[1]), .D(d[1]), .D_VALID(dv[1]), .D_BP(bp[1]),
        .FLIT_CNT(cnt[1]), .ROUTE_ERR(rerr[1]), .SEQ_ERR(serr[1]), .DONE(done[1]), .PASS(pass[1]));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model
    logic [15:0] m_lfsr [2];
    logic [3:0]  m_bp   [2];
    logic [3:0]  m_acc  [2];
    logic [3:0]  m_rerr [2];
    logic [3:0]  m_serr [2];
    int          m_cnt  [2][4];
    logic [31:0] m_exp  [2][4][4];
    int          m_total [2];
    int          m_idle  [2];
    bit          m_done  [2];
    bit          m_pass  [2];

    task automatic model_reset(input int k);
        m_lfsr[k] = 16'hACE1;
        m_bp[k] = 4'h0; m_acc[k] = 4'h0; m_rerr[k] = 4'h0; m_serr[k] = 4'h0;
        m_total[k] = 0; m_idle[k] = 0; m_done[k] = 0; m_pass[k] = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[k][i] = 0;
            for (int s = 0; s < 4; s++) m_exp[k][i][s] = 32'd0;
        end
    endtask

    task automatic model_step(input int k);
        int n;
        int dst;
        int src;
        int fb;
        logic [31:0] seq;
        if (rst[k]) begin
            model_reset(k);
            return;
        end
        if (m_done[k]) begin
            m_acc[k] = 4'h0;
            m_bp[k] = 4'hF;
            return;
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            m_acc[k][i] = dv[k][i] && !m_bp[k][i];
            if (m_acc[k][i]) begin
                n++;
                if (m_cnt[k][i] < 65535) m_cnt[k][i]++;
                dst = int'(d[k][i][33:32]);
                src = int'(d[k][i][35:34]);
                seq = d[k][i][31:0];
                if (dst != i) m_rerr[k][i] = 1'b1;
                else begin
                    if (seq != m_exp[k][i][src]) m_serr[k][i] = 1'b1;
                    m_exp[k][i][src] = seq + 32'd1;
                end
            end
        end
        if (m_total[k] + n >= P_NF[k]) begin
            m_done[k] = 1;
            m_pass[k] = (m_rerr[k] == 4'h0) && (m_serr[k] == 4'h0);
        end else if (n == 0 && m_idle[k] == P_TO[k] - 1) begin
            m_done[k] = 1;
            m_pass[k] = 0;
        end
        m_total[k] = (m_total[k] + n > 20'hFFFFF) ? 20'hFFFFF : m_total[k] + n;
        m_idle[k] = (n > 0) ? 0 : m_idle[k] + 1;
        for (int i = 0; i < 4; i++)
            m_bp[k][i] = m_done[k] || ((P_BP[k] != 0) && (((int'(m_lfsr[k]) >> (4 * i)) % 4) == 0));
        fb = ((int'(m_lfsr[k])) ^ (int'(m_lfsr[k]) >> 2) ^ (int'(m_lfsr[k]) >> 3) ^ (int'(m_lfsr[k]) >> 5)) & 1;
        m_lfsr[k] = 16'((int'(m_lfsr[k]) >> 1) | (fb << 15));
    endtask

    always @(posedge CLK)
        for (int k = 0; k < 2; k++) model_step(k);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] model_cnt(input int k);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[16*i +: 16] = 16'(m_cnt[k][i]);
        return v;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d D_BP", k), 64'(bp[k]), 64'(m_bp[k]));
                check($sformatf("dut%0d flags", k), 64'({rerr[k], serr[k], done[k], pass[k]}),
                      64'({m_rerr[k], m_serr[k], m_done[k], m_pass[k]}));
                check($sformatf("dut%0d FLIT_CNT", k), cnt[k], model_cnt(k));
            end
        end
    end

    // Stimulus helpers
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr(input int k);
        dv[k] = 4'h0;
        d[k]  = '0;
    endtask

    task automatic set_flit(input int k, input int port, input int src, input int dst, input logic [31:0] seq);
        d[k][port]  = {28'd0, src[1:0], dst[1:0], seq};
        dv[k][port] = 1'b1;
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        clr(k);
        cyc();
        cyc();
        rst[k] = 1'b0;
    endtask

    logic [31:0] gen_next [4][4];
    int          budget;

    task automatic gen_clear();
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 4; s++) gen_next[i][s] = 32'd0;
    endtask

    task automatic gen_update();
        for (int i = 0; i < 4; i++)
            if (m_acc[1][i] && int'(d[1][i][33:32]) == i)
                gen_next[i][int'(d[1][i][35:34])] = d[1][i][31:0] + 32'd1;
    endtask

    task automatic gen_random(input bit inject);
        int src;
        int dst;
        logic [31:0] seq;
        clr(1);
        for (int i = 0; i < 4; i++) begin
            if (!inject || $urandom_range(1) == 1) begin
                src = int'($urandom_range(3));
                dst = i;
                seq = gen_next[i][src];
                if (inject && $urandom_range(15) == 0) dst = (i + 1 + int'($urandom_range(2))) % 4;
                if (inject && $urandom_range(15) == 0) seq = ($urandom_range(1) == 1) ? 32'hFFFFFFFF : $urandom;
                set_flit(1, i, src, dst, seq);
            end
        end
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        clr(0); clr(1);
        cyc(); cyc();
        chk_en = 1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // reset state
        check("reset DONE/PASS", 64'({done[0], pass[0]}), 64'd0);
        check("reset D_BP", 64'(bp[0]), 64'd0);
        check("reset FLIT_CNT", cnt[0], 64'd0);
        check("reset errors", 64'({rerr[0], serr[0]}), 64'd0);

        // eight in-order flits on port 0
        do_reset(0);
        for (int s = 0; s < 8; s++) begin
            set_flit(0, 0, 0, 0, 32'(s));
            cyc();
            if (s == 6) check("t034 DONE before last", 64'(done[0]), 64'd0);
        end
        clr(0);
        check("t034 FLIT_CNT0", 64'(cnt[0][0]), 64'd8);
        check("t034 DONE/PASS", 64'({done[0], pass[0]}), 64'b11);
        check("t034 D_BP", 64'(bp[0]), 64'hF);
        set_flit(0, 0, 0, 0, 32'd8);
        cyc(); cyc();
        clr(0);
        check("t034 terminal cnt", 64'(cnt[0][0]), 64'd8);

        // all four ports in parallel
        do_reset(0);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) set_flit(0, i, i, i, 32'(c));
            cyc();
            if (c == 0) check("t035 DONE after 4", 64'(done[0]), 64'd0);
        end
        clr(0);
        check("t035 FLIT_CNT", cnt[0], 64'h0002_0002_0002_0002);
        check("t035 PASS", 64'({done[0], pass[0]}), 64'b11);

        // misrouted flit on port 2
        do_reset(0);
        set_flit(0, 2, 0, 1, 32'd0);
        cyc();
        clr(0);
        check("t036 ROUTE_ERR", 64'(rerr[0]), 64'b0100);
        for (int s = 0; s < 7; s++) begin
            set_flit(0, 0, 0, 0, 32'(s));
            cyc();
        end
        clr(0);
        check("t036 DONE/PASS", 64'({done[0], pass[0]}), 64'b10);

        // sequence gap with resync on port 1
        do_reset(0);
        foreach (P_NF[j]) begin end
        for (int j = 0; j < 4; j++) begin
            set_flit(0, 1, 3, 1, (j < 2) ? 32'(j) : 32'(j + 1));
            cyc();
            if (j == 1) check("t037 SEQ_ERR before gap", 64'(serr[0]), 64'd0);
            if (j == 2) check("t037 SEQ_ERR at gap", 64'(serr[0]), 64'b0010);
        end
        clr(0);
        check("t037 SEQ_ERR after resync", 64'(serr[0]), 64'b0010);
        for (int s = 0; s < 4; s++) begin
            set_flit(0, 0, 0, 0, 32'(s));
            cyc();
        end
        clr(0);
        check("t037 DONE/PASS", 64'({done[0], pass[0]}), 64'b10);

        // idle timeout then reset out of FAIL
        do_reset(0);
        repeat (15) cyc();
        check("t038 DONE at 15", 64'(done[0]), 64'd0);
        cyc();
        check("t038 FAIL at 16", 64'({done[0], pass[0]}), 64'b10);
        rst[0] = 1'b1;
        cyc();
        check("t038 reset outputs", 64'({bp[0], rerr[0], serr[0], done[0], pass[0]}), 64'd0);
        rst[0] = 1'b0;

        // LFSR backpressure, always-valid correct traffic
        do_reset(1);
        gen_clear();
        check("t039 D_BP after reset", 64'(bp[1]), 64'd0);
        budget = 0;
        while (!m_done[1] && budget < 1000) begin
            gen_random(1'b0);
            cyc();
            gen_update();
            if (budget == 0) check("t039 D_BP from seed", 64'(bp[1]), 64'b0100);
            if (budget == 1) check("t039 D_BP second", 64'(bp[1]), 64'b0001);
            budget++;
        end
        clr(1);
        check("t039 finished in budget", 64'(budget < 1000), 64'd1);
        check("t039 PASS", 64'({done[1], pass[1], serr[1], rerr[1]}), 64'({1'b1, 1'b1, 4'h0, 4'h0}));

        // random traffic with injected errors and a mid-test reset
        do_reset(1);
        gen_clear();
        repeat (40) begin
            gen_random(1'b1);
            cyc();
            gen_update();
        end
        do_reset(1);
        gen_clear();
        check("mid reset FLIT_CNT", cnt[1], 64'd0);
        budget = 0;
        while (!m_done[1] && budget < 2000) begin
            gen_random(1'b1);
            cyc();
            gen_update();
            budget++;
        end
        check("random finished in budget", 64'(budget < 2000), 64'd1);
        repeat (3) begin
            gen_random(1'b1);
            cyc();
        end
        clr(1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
